video_fx_pipe: RTL and testbench

- Parametrised video effect stage sitting between a pixel generator and the vga2hdmi_ddr serializer, in the pixel clock domain.
- Replaces the fixed single-effect filter with a run-time selectable mode set: bypass, horizontal sharpen, grayscale, scanline dim.
- Colour depth and pipeline depth are configurable.
- Sync and blank are delayed to exactly match colour latency.
- A mode change takes effect only at frame start, so no frame is torn.

---
 rtl/video_fx_pipe.sv | 132 +++++++++++++
 tb/tb_video_fx_pipe.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/video_fx_pipe.sv
// rtl/video_fx_pipe.sv - run-time selectable pixel effect stage with aligned sync/blank delay
module video_fx_pipe #(
    parameter int C_depth      = 8,
    parameter int C_delay      = 0,
    parameter int C_scan_shift = 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [1:0]         mode,
    input  logic               in_blank,
    input  logic               in_hsync,
    input  logic               in_vsync,
    input  logic [C_depth-1:0] in_red,
    input  logic [C_depth-1:0] in_green,
    input  logic [C_depth-1:0] in_blue,
    output logic               out_blank,
    output logic               out_hsync,
    output logic               out_vsync,
    output logic [C_depth-1:0] out_red,
    output logic [C_depth-1:0] out_green,
    output logic [C_depth-1:0] out_blue,
    output logic [1:0]         active_mode
);
    localparam int W  = C_depth;
    localparam int PW = 3 * W + 3;
    localparam logic [PW-1:0] RST_BUS = {1'b1, {(PW-1){1'b0}}};

    logic [1:0]   s1_mode;
    logic         s1_blank, s1_hsync, s1_vsync;
    logic         s1_hsync_d, s1_vsync_d;
    logic [W-1:0] s1_red, s1_green, s1_blue;
    logic [W-1:0] p_red, p_green, p_blue;
    logic         line_odd;
    logic [PW-1:0] s2_bus;
    logic [PW-1:0] out_bus;

    logic         hs_edge, vs_edge, line_next;
    logic [1:0]   eff_mode;
    logic [W+1:0] gsum;
    logic [W-1:0] gray;
    logic [W-1:0] fx_red, fx_green, fx_blue;

    function automatic logic [W-1:0] sharpen(input logic [W-1:0] x, input logic [W-1:0] p);
        logic signed [W+1:0] t;
        t = $signed({1'b0, x, 1'b0}) - $signed({2'b00, p});
        if (t[W+1]) return '0;
        if (t[W])   return '1;
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] effect(input logic [1:0] m, input logic odd,
                                            input logic [W-1:0] x, input logic [W-1:0] p,
                                            input logic [W-1:0] g);
        case (m)
            2'd0:    return x;
            2'd1:    return sharpen(x, p);
            2'd2:    return g;
            default: return odd ? (x >> C_scan_shift) : x;
        endcase
    endfunction

    // The pixel carrying the vsync edge already uses the newly requested mode.
    always_comb begin
        hs_edge   = s1_hsync & ~s1_hsync_d;
        vs_edge   = s1_vsync & ~s1_vsync_d;
        eff_mode  = vs_edge ? s1_mode : active_mode;
        line_next = vs_edge ? 1'b0 : (hs_edge ? ~line_odd : line_odd);
        gsum      = {2'b00, s1_red} + {1'b0, s1_green, 1'b0} + {2'b00, s1_blue};
        gray      = gsum[W+1:2];
        fx_red    = s1_blank ? '0 : effect(eff_mode, line_next, s1_red,   p_red,   gray);
        fx_green  = s1_blank ? '0 : effect(eff_mode, line_next, s1_green, p_green, gray);
        fx_blue   = s1_blank ? '0 : effect(eff_mode, line_next, s1_blue,  p_blue,  gray);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1_mode     <= 2'd0;
            s1_blank    <= 1'b1;
            s1_hsync    <= 1'b0;
            s1_vsync    <= 1'b0;
            s1_hsync_d  <= 1'b0;
            s1_vsync_d  <= 1'b0;
            s1_red      <= '0;
            s1_green    <= '0;
            s1_blue     <= '0;
            p_red       <= '0;
            p_green     <= '0;
            p_blue      <= '0;
            line_odd    <= 1'b0;
            active_mode <= 2'd0;
            s2_bus      <= RST_BUS;
        end else begin
            s1_mode    <= mode;
            s1_blank   <= in_blank;
            s1_hsync   <= in_hsync;
            s1_vsync   <= in_vsync;
            s1_hsync_d <= s1_hsync;
            s1_vsync_d <= s1_vsync;
            s1_red     <= in_red;
            s1_green   <= in_green;
            s1_blue    <= in_blue;
            p_red      <= s1_blank ? '0 : s1_red;
            p_green    <= s1_blank ? '0 : s1_green;
            p_blue     <= s1_blank ? '0 : s1_blue;
            line_odd   <= line_next;
            if (vs_edge) begin
                active_mode <= s1_mode;
            end
            s2_bus <= {s1_blank, s1_hsync, s1_vsync, fx_red, fx_green, fx_blue};
        end
    end

    generate
        if (C_delay == 0) begin : g_nodelay
            assign out_bus = s2_bus;
        end else begin : g_delay
            logic [PW-1:0] dly [C_delay];
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    for (int i = 0; i < C_delay; i++) dly[i] <= RST_BUS;
                end else begin
                    dly[0] <= s2_bus;
                    for (int i = 1; i < C_delay; i++) dly[i] <= dly[i-1];
                end
            end
            assign out_bus = dly[C_delay-1];
        end
    endgenerate

    assign {out_blank, out_hsync, out_vsync, out_red, out_green, out_blue} = out_bus;

endmodule

// File: tb/tb_video_fx_pipe.sv
// tb/tb_video_fx_pipe.sv - self-checking bench for video_fx_pipe with C_delay 0 and 3
module tb_video_fx_pipe;
    localparam int MAXN = 4096;

    logic       clk = 1'b0;
    logic       resetn;
    logic [1:0] mode;
    logic       in_blank, in_hsync, in_vsync;
    logic [7:0] in_red, in_green, in_blue;

    logic       o0_blank, o0_hsync, o0_vsync;
    logic [7:0] o0_red, o0_green, o0_blue;
    logic [1:0] o0_am;
    logic       o3_blank, o3_hsync, o3_vsync;
    logic [7:0] o3_red, o3_green, o3_blue;
    logic [1:0] o3_am;

    int edge_n = 0, last_rst = -1, last_idx = 0;
    int n_checks = 0, n_pass = 0;
    int e_r[MAXN], e_g[MAXN], e_b[MAXN], mode_after[MAXN];
    bit e_bl[MAXN], e_hs[MAXN], e_vs[MAXN];

    video_fx_pipe #(.C_depth(8), .C_delay(0), .C_scan_shift(1)) dut0 (
        .clk(clk), .resetn(resetn), .mode(mode),
        .in_blank(in_blank), .in_hsync(in_hsync), .in_vsync(in_vsync),
        .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
        .out_blank(o0_blank), .out_hsync(o0_hsync), .out_vsync(o0_vsync),
        .out_red(o0_red), .out_green(o0_green), .out_blue(o0_blue),
        .active_mode(o0_am)
    );

    video_fx_pipe #(.C_depth(8), .C_delay(3), .C_scan_shift(1)) dut3 (
        .clk(clk), .resetn(resetn), .mode(mode),
        .in_blank(in_blank), .in_hsync(in_hsync), .in_vsync(in_vsync),
        .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
        .out_blank(o3_blank), .out_hsync(o3_hsync), .out_vsync(o3_vsync),
        .out_red(o3_red), .out_green(o3_green), .out_blue(o3_blue),
        .active_mode(o3_am)
    );

    always #5 clk = ~clk;

    // Reference: effect of each sampled pixel, indexed by the clock edge that sampled it.
    initial begin : model
        int n, cur_mode, line, prev_hs, prev_vs, gray, y;
        int pp[3];
        int x[3];
        cur_mode = 0; line = 0; prev_hs = 0; prev_vs = 0; pp = '{0, 0, 0};
        forever begin
            @(posedge clk);
            n = edge_n;
            if (!resetn) begin
                last_rst = n;
                cur_mode = 0; line = 0; prev_hs = 0; prev_vs = 0; pp = '{0, 0, 0};
                e_bl[n] = 1'b1; e_hs[n] = 1'b0; e_vs[n] = 1'b0;
                e_r[n] = 0; e_g[n] = 0; e_b[n] = 0;
                mode_after[n] = 0;
            end else begin
                x = '{int'(in_red), int'(in_green), int'(in_blue)};
                if (in_vsync && prev_vs == 0) begin
                    cur_mode = int'(mode);
                    line = 0;
                end else if (in_hsync && prev_hs == 0) begin
                    line = line + 1;
                end
                prev_hs = int'(in_hsync);
                prev_vs = int'(in_vsync);
                gray = (x[0] + 2 * x[1] + x[2]) / 4;
                for (int c = 0; c < 3; c++) begin
                    case (cur_mode)
                        0: y = x[c];
                        1: begin
                            y = 2 * x[c] - pp[c];
                            if (y < 0) y = 0;
                            if (y > 255) y = 255;
                        end
                        2: y = gray;
                        default: y = (line % 2 == 1) ? x[c] / 2 : x[c];
                    endcase
                    if (in_blank) y = 0;
                    pp[c] = in_blank ? 0 : x[c];
                    if (c == 0) e_r[n] = y;
                    else if (c == 1) e_g[n] = y;
                    else e_b[n] = y;
                end
                e_bl[n] = in_blank; e_hs[n] = in_hsync; e_vs[n] = in_vsync;
                mode_after[n] = cur_mode;
            end
            edge_n = n + 1;
        end
    end

    task automatic check(input string nm, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, got, want);
    endtask

    task automatic cmp_dut(input string nm, input int d, input logic [28:0] got);
        int m, src;
        logic [28:0] want;
        m = edge_n - 1;
        src = m - 1 - d;
        if (src < 0 || last_rst >= src)
            want[26:0] = {1'b1, 26'd0};
        else
            want[26:0] = {e_bl[src], e_hs[src], e_vs[src], 8'(e_r[src]), 8'(e_g[src]), 8'(e_b[src])};
        want[28:27] = (last_rst == m) ? 2'd0 : 2'(mode_after[m-1]);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s edge=%0d: got {mode,blank,hs,vs,r,g,b}=%h, expected %h", nm, m, got, want);
    endtask

    initial begin : compare
        forever begin
            @(negedge clk);
            if (edge_n > 0) begin
                cmp_dut("dut0_stream", 0, {o0_am, o0_blank, o0_hsync, o0_vsync, o0_red, o0_green, o0_blue});
                cmp_dut("dut3_stream", 3, {o3_am, o3_blank, o3_hsync, o3_vsync, o3_red, o3_green, o3_blue});
            end
        end
    end

    task automatic px(input bit bl, input bit hs, input bit vs, input int r, input int g, input int b);
        in_blank = bl; in_hsync = hs; in_vsync = vs;
        in_red = 8'(r); in_green = 8'(g); in_blue = 8'(b);
        last_idx = edge_n;
        @(negedge clk);
    endtask

    task automatic blanks(input int n);
        for (int i = 0; i < n; i++) px(1, 0, 0, 0, 0, 0);
    endtask

    task automatic vpulse();
        px(1, 0, 1, 0, 0, 0);
        px(1, 0, 1, 0, 0, 0);
        blanks(2);
    endtask

    task automatic hpulse();
        blanks(1);
        px(1, 1, 0, 0, 0, 0);
        px(1, 1, 0, 0, 0, 0);
        blanks(1);
    endtask

    task automatic flat_line(input int v, input int n, output int idx);
        for (int i = 0; i < n; i++) px(0, 0, 0, v, v, v);
        idx = last_idx;
    endtask

    initial begin : stim
        int ramp_idx, pre_idx, g_idx, g2_idx, l0, l1, l2, l3, l4;
        int s_idx[5];
        int sharp_r[5];
        sharp_r = '{10, 10, 200, 200, 5};
        resetn = 1'b0; mode = 2'd0;
        ramp_idx = 0;
        blanks(3);
        check("reset_blank0", int'(o0_blank), 1);
        check("reset_red3", int'(o3_red), 0);
        check("reset_mode0", int'(o0_am), 0);

        resetn = 1'b1;
        vpulse();
        for (int ln = 0; ln < 4; ln++) begin
            for (int i = 0; i < 64; i++) begin
                px(0, 0, 0, ln * 64 + i, 255 - (ln * 64 + i), (ln * 64 + i) ^ 8'h55);
                if (ln == 1 && i == 5) ramp_idx = last_idx;
            end
            hpulse();
        end
        check("bypass_pin_r", e_r[ramp_idx], 69);
        check("bypass_pin_g", e_g[ramp_idx], 186);

        mode = 2'd2;
        px(0, 0, 0, 100, 200, 40);
        pre_idx = last_idx;
        for (int i = 0; i < 4; i++) px(0, 0, 0, 100, 200, 40);
        check("latch_hold_mode", int'(o0_am), 0);
        check("pre_edge_r", e_r[pre_idx], 100);
        check("pre_edge_g", e_g[pre_idx], 200);
        vpulse();
        check("latch_mode_dut0", int'(o0_am), 2);
        check("latch_mode_dut3", int'(o3_am), 2);
        px(0, 0, 0, 100, 200, 40);
        g_idx = last_idx;
        px(0, 0, 0, 20, 40, 60);
        g2_idx = last_idx;
        hpulse();
        check("gray_r", e_r[g_idx], 135);
        check("gray_g", e_g[g_idx], 135);
        check("gray_b", e_b[g_idx], 135);
        check("gray2_b", e_b[g2_idx], 40);

        mode = 2'd1;
        vpulse();
        blanks(1);
        for (int i = 0; i < 5; i++) begin
            px(0, 0, 0, sharp_r[i], 0, 0);
            s_idx[i] = last_idx;
        end
        check("sharp_0", e_r[s_idx[0]], 20);
        check("sharp_1", e_r[s_idx[1]], 10);
        check("sharp_2", e_r[s_idx[2]], 255);
        check("sharp_3", e_r[s_idx[3]], 200);
        check("sharp_4", e_r[s_idx[4]], 0);
        hpulse();

        mode = 2'd3;
        vpulse();
        flat_line(8'hF0, 8, l0);
        hpulse();
        flat_line(8'hF0, 8, l1);
        hpulse();
        flat_line(8'hF0, 8, l2);
        hpulse();
        flat_line(8'hF0, 8, l3);
        blanks(1);
        px(1, 1, 1, 0, 0, 0);
        px(1, 1, 1, 0, 0, 0);
        blanks(1);
        flat_line(8'hF0, 8, l4);
        check("scan_line0", e_r[l0], 240);
        check("scan_line1", e_r[l1], 120);
        check("scan_line2", e_g[l2], 240);
        check("scan_line3", e_b[l3], 120);
        check("scan_hv_clear", e_r[l4], 240);

        resetn = 1'b0;
        px(0, 0, 0, 8'h11, 8'h11, 8'h11);
        check("midrst_red0", int'(o0_red), 0);
        check("midrst_blank0", int'(o0_blank), 1);
        check("midrst_red3", int'(o3_red), 0);
        check("midrst_blank3", int'(o3_blank), 1);
        check("midrst_mode3", int'(o3_am), 0);
        resetn = 1'b1;
        px(0, 0, 0, 8'h33, 8'h33, 8'h33);
        for (int i = 0; i < 3; i++) px(0, 0, 0, 8'h44, 8'h44, 8'h44);
        check("midrst_fill3", int'(o3_blank), 1);
        px(0, 0, 0, 8'h44, 8'h44, 8'h44);
        check("midrst_resume_r3", int'(o3_red), 8'h33);
        check("midrst_resume_blank3", int'(o3_blank), 0);
        blanks(8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
